// File: rtl/array_feeder.sv
// array_feeder: loads ROWS weight words into a systolic array, then streams data vectors skewed one cycle per row.
// Optional macro ARRAY_FEEDER_STATS_EN adds a 16-bit saturating accepted-vector counter on vec_count.
module array_feeder #(
  parameter int ROWS = 4,
  parameter int DW   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [DW*ROWS-1:0] w_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW*ROWS-1:0] in_data,
  input  logic               in_last,
  output logic [DW*ROWS-1:0] win_o,
  output logic               wwrite_o,
  output logic [DW*ROWS-1:0] datain_o,
  output logic [ROWS-1:0]    active_o,
  output logic               busy,
`ifdef ARRAY_FEEDER_STATS_EN
  output logic [15:0]        vec_count,
`endif
  output logic               done
);

  localparam int CW = $clog2(ROWS);
  localparam logic [CW-1:0] LAST    = CW'(ROWS - 1);
  localparam logic [CW-1:0] PRELAST = CW'(ROWS - 2);

  typedef enum logic [1:0] {IDLE, WLOAD, STREAM, DRAIN} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              w_ready_q;
  logic              in_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              wwrite_q;
  logic [DW*ROWS-1:0] win_q;

  logic w_fire;
  logic in_fire;

  assign w_fire  = w_valid && w_ready_q;
  assign in_fire = in_valid && in_ready_q;

  // Handshake and status outputs are registered alongside the state, so they change only with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      w_ready_q  <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= WLOAD;
            cnt_q     <= '0;
            w_ready_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        WLOAD: begin
          if (w_fire) begin
            if (cnt_q == LAST) begin
              state_q    <= STREAM;
              cnt_q      <= '0;
              w_ready_q  <= 1'b0;
              in_ready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        STREAM: begin
          if (in_fire && in_last) begin
            state_q    <= DRAIN;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            done_q <= (cnt_q == PRELAST);
          end
        end
        default: begin
          state_q    <= IDLE;
          cnt_q      <= '0;
          w_ready_q  <= 1'b0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wwrite_q <= 1'b0;
      win_q    <= '0;
    end else begin
      wwrite_q <= w_fire;
      if (w_fire) begin
        win_q <= w_data;
      end
    end
  end

  // Lane r is delayed through r+1 stages; a non-transfer cycle enters as a zero bubble.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [r:0][DW-1:0] sh_q;
    logic [r:0]         v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh_q <= '0;
        v_q  <= '0;
      end else begin
        sh_q[0] <= in_fire ? in_data[r*DW +: DW] : '0;
        v_q[0]  <= in_fire;
        for (int s = 1; s <= r; s++) begin
          sh_q[s] <= sh_q[s-1];
          v_q[s]  <= v_q[s-1];
        end
      end
    end

    assign datain_o[r*DW +: DW] = sh_q[r];
    assign active_o[r]          = v_q[r];
  end

`ifdef ARRAY_FEEDER_STATS_EN
  logic [15:0] vcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vcnt_q <= '0;
    end else if (state_q == IDLE && start) begin
      vcnt_q <= '0;
    end else if (in_fire && vcnt_q != 16'hFFFF) begin
      vcnt_q <= vcnt_q + 16'd1;
    end
  end

  assign vec_count = vcnt_q;
`endif

  assign w_ready  = w_ready_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign win_o    = win_q;
  assign wwrite_o = wwrite_q;

endmodule

// File: tb/tb_array_feeder.sv
// Self-checking bench for array_feeder: a cycle-level job model plus an acceptance log predicts every output each cycle.
module tb_array_feeder;
  localparam int ROWS = 4;
  localparam int DW   = 8;
  localparam int W    = ROWS * DW;
  localparam int LIM  = 400;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         w_valid = 1'b0;
  logic [W-1:0] w_data = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         w_ready, in_ready, wwrite_o, busy, done;
  logic [W-1:0] win_o, datain_o;
  logic [ROWS-1:0] active_o;
`ifdef ARRAY_FEEDER_STATS_EN
  logic [15:0]  vec_count;
`endif

  array_feeder #(.ROWS(ROWS), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .win_o    (win_o),
    .wwrite_o (wwrite_o),
    .datain_o (datain_o),
    .active_o (active_o),
    .busy     (busy),
`ifdef ARRAY_FEEDER_STATS_EN
    .vec_count(vec_count),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int base = 0;
  // Job model: 0 idle, 1 loading weights, 2 streaming, 3 draining.
  int ph = 0;
  int wcnt = 0;
  int dcnt = 0;
  int vcnt = 0;
  logic         m_wwr = 1'b0;
  logic [W-1:0] m_win = '0;
  logic         acc_v [0:4095];
  logic [W-1:0] acc_d [0:4095];
  int t0, dcyc, icyc;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [W-1:0] rw();
    return W'($urandom);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0]    ed;
    logic [ROWS-1:0] ea;
    int src;
    ed = '0;
    ea = '0;
    for (int r = 0; r < ROWS; r++) begin
      src = cyc - 1 - r;
      if (src >= base && acc_v[src]) begin
        ed[r*DW +: DW] = acc_d[src][r*DW +: DW];
        ea[r] = 1'b1;
      end
    end
    check("busy",     64'(busy),     64'(ph != 0));
    check("w_ready",  64'(w_ready),  64'(ph == 1));
    check("in_ready", 64'(in_ready), 64'(ph == 2));
    check("done",     64'(done),     64'(ph == 3 && dcnt == ROWS - 1));
    check("wwrite",   64'(wwrite_o), 64'(m_wwr));
    check("win",      64'(win_o),    64'(m_win));
    check("datain",   64'(datain_o), 64'(ed));
    check("active",   64'(active_o), 64'(ea));
`ifdef ARRAY_FEEDER_STATS_EN
    check("vec_count", 64'(vec_count), 64'(vcnt));
`endif
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic cycle(input logic st, input logic wv, input logic [W-1:0] wd,
                       input logic iv, input logic [W-1:0] id, input logic il);
    logic acc;
    start = st; w_valid = wv; w_data = wd;
    in_valid = iv; in_data = id; in_last = il;
    check_outputs();
    acc = (ph == 2) && iv;
    acc_v[cyc] = acc;
    acc_d[cyc] = id;
    if (ph == 0 && st) vcnt = 0;
    else if (acc && vcnt < 65535) vcnt++;
    if (ph == 1 && wv) begin
      m_win = wd;
      m_wwr = 1'b1;
    end else begin
      m_wwr = 1'b0;
    end
    case (ph)
      0: if (st) begin ph = 1; wcnt = 0; end
      1: if (wv) begin wcnt++; if (wcnt == ROWS) ph = 2; end
      2: if (iv && il) begin ph = 3; dcnt = 0; end
      3: if (dcnt == ROWS - 1) ph = 0; else dcnt++;
      default: ph = 0;
    endcase
    @(posedge clk);
    #2;
    cyc++;
    if (cyc >= 4000) begin
      fails++;
      $display("FAIL cycle_budget cyc=%0d expected below 4000", cyc);
      finish_run();
    end
  endtask

  task automatic idle_cycle();
    cycle(1'b0, rb(), rw(), rb(), rw(), rb());
  endtask

  task automatic run_job(input int nvec, input int gap, input bit rnd_w);
    int sent;
    int guard;
    logic wv, iv, lst;
    logic [W-1:0] id;
    sent = 0;
    guard = 0;
    cycle(1'b1, rb(), rw(), rb(), rw(), rb());
    while (ph == 1 && guard < LIM) begin
      wv = rnd_w ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      cycle(rb(), wv, rw(), rb(), rw(), rb());
      guard++;
    end
    while (ph == 2 && guard < LIM) begin
      iv  = ($urandom_range(0, 99) >= 32'(gap));
      lst = iv && (sent == nvec - 1);
      id  = rw();
      cycle(rb(), rb(), rw(), iv, id, iv ? lst : rb());
      if (iv) sent++;
      guard++;
    end
    while (ph != 0 && guard < LIM) begin
      idle_cycle();
      guard++;
    end
    tests++;
    assert (guard < LIM) else begin
      fails++;
      $error("FAIL job_timeout observed=%0d cycles expected below %0d", guard, LIM);
    end
  endtask

  task automatic do_reset();
    start = 1'b0; w_valid = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_done",     64'(done),     64'd0);
    check("rst_w_ready",  64'(w_ready),  64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_wwrite",   64'(wwrite_o), 64'd0);
    check("rst_win",      64'(win_o),    64'd0);
    check("rst_datain",   64'(datain_o), 64'd0);
    check("rst_active",   64'(active_o), 64'd0);
`ifdef ARRAY_FEEDER_STATS_EN
    check("rst_vec_count", 64'(vec_count), 64'd0);
`endif
    @(posedge clk);
    #2;
    cyc++;
    check("rst_hold_done",   64'(done),     64'd0);
    check("rst_hold_active", 64'(active_o), 64'd0);
    rst_n = 1'b1;
    base = cyc;
    ph = 0; wcnt = 0; dcnt = 0; vcnt = 0;
    m_wwr = 1'b0;
    m_win = '0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      acc_v[i] = 1'b0;
      acc_d[i] = '0;
    end

    // Power-on reset, then release between edges.
    do_reset();

    // Directed job: weights 1..4 back-to-back, vector, one bubble, last vector.
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int k = 1; k <= ROWS; k++) cycle(1'b0, 1'b1, W'(k), 1'b1, rw(), 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, W'(32'h40302010), 1'b0);
    cycle(1'b1, 1'b1, rw(), 1'b0, rw(), 1'b1);
    cycle(1'b0, 1'b1, rw(), 1'b1, W'(32'h80F0E0D0), 1'b1);
    for (int k = 0; k < ROWS + 2; k++) idle_cycle();

    // Single last vector: done lands ROWS cycles after acceptance, idle one later.
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int k = 0; k < ROWS; k++) cycle(1'b0, 1'b1, rw(), 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, W'(32'h7F8001FF), 1'b1);
    t0 = cyc - 1;
    dcyc = -1;
    icyc = -1;
    for (int k = 0; k < 8; k++) begin
      if (done === 1'b1 && dcyc < 0) dcyc = cyc;
      if (busy === 1'b0 && icyc < 0) icyc = cyc;
      idle_cycle();
    end
    check("single_done_cycle", 64'(dcyc - t0), 64'(ROWS));
    check("single_idle_cycle", 64'(icyc - t0), 64'(ROWS + 1));

    // Randomised jobs with gaps in both handshakes.
    run_job(6, 30, 1'b1);
    run_job(3, 0, 1'b0);
    run_job(10, 50, 1'b1);
    run_job(1, 0, 1'b1);
    for (int k = 0; k < 3; k++) idle_cycle();

    // Reset with three vectors still in the skew pipeline.
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int k = 0; k < ROWS; k++) cycle(1'b0, 1'b1, rw(), 1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, '0, 1'b1, rw(), 1'b0);
    do_reset();
    run_job(2, 0, 1'b0);
    run_job(7, 25, 1'b1);

`ifdef ARRAY_FEEDER_STATS_EN
    run_job(5, 20, 1'b1);
    check("stats_five", 64'(vec_count), 64'd5);
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    check("stats_clear", 64'(vec_count), 64'd0);
    for (int k = 0; k < ROWS; k++) cycle(1'b0, 1'b1, rw(), 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, rw(), 1'b1);
    for (int k = 0; k < ROWS + 1; k++) idle_cycle();
`endif

    finish_run();
  end
endmodule
